// File: rtl/count_display.sv
// Two-digit multiplexed 7-segment driver for an 8-bit count with frame-synchronous snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the high digit when its nibble is zero.

//  state | meaning
//  ------+----------------------------------------------
//  DIG0  | low nibble slot, an = 2'b10
//  DIG1  | high nibble slot, an = 2'b01 (or 2'b11 if blanked)

module count_display #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count,
    input  logic       blank,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } state_t;

    localparam logic [15:0] PRESC_TC = 16'(PRESCALE - 1);

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  snap_q,  snap_d;
    logic [1:0]  an_q,    an_d;
    logic [6:0]  seg_q,   seg_d;
    logic        frame_done_q, frame_done_d;
    logic        tick;
    logic [3:0]  nib;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            state_q      <= DIG0;
            snap_q       <= 8'h00;
            an_q         <= 2'b10;
            seg_q        <= 7'b1000000;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            state_q      <= state_d;
            snap_q       <= snap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        tick         = (presc_q == PRESC_TC);
        presc_d      = tick ? '0 : presc_q + 16'd1;
        state_d      = state_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        an_d         = 2'b10;

        if (tick) begin
            if (state_q == DIG0) begin
                state_d = DIG1;
            end else begin
                state_d      = DIG0;
                snap_d       = count;
                frame_done_d = 1'b1;
            end
        end

        // Outputs are derived from the next state/snapshot so they change on the same edge.
        nib   = (state_d == DIG0) ? snap_d[3:0] : snap_d[7:4];
        seg_d = decode(nib);

        if (blank) begin
            an_d = 2'b11;
        end else if (state_d == DIG0) begin
            an_d = 2'b10;
        end else begin
            an_d = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
            if (nib == 4'h0) an_d = 2'b11;
`else
`endif
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter PRESCALE, default 4, is the number of clk cycles per digit slot; legal range is 2..65535.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 count  input  8  binary value from the upstream up/down counter.
REQ-005 blank  input  1  when high, both anodes are forced off.
REQ-006 an  output  2  digit anodes, active-low; an[0] is the low nibble and an[1] is the high nibble.
REQ-007 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 frame_done  output  1  one-cycle pulse marking the start of a new scan frame.

Function
REQ-009 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick is asserted during the cycle in which the prescaler equals PRESCALE-1.
REQ-010 The digit FSM SHALL have two states, DIG0 and DIG1, and SHALL toggle only on the edge where tick is high.
REQ-011 On the DIG1->DIG0 edge, the snapshot register SHALL load count and frame_done SHALL be 1 for exactly that following cycle; it is 0 in every other cycle.
REQ-012 count SHALL be sampled only at the frame boundary; changes to count within a frame SHALL NOT alter the displayed digits (no tearing).
REQ-013 an, seg and frame_done SHALL be registered and SHALL take the values for the new state on the same edge that the FSM changes state, with no extra latency.
REQ-014 seg SHALL show the newly loaded snapshot low nibble in the same cycle as frame_done.
REQ-015 In DIG0, an SHALL be 2'b10 and seg SHALL be decode(snap[3:0]).
REQ-016 In DIG1, an SHALL be 2'b01 and seg SHALL be decode(snap[7:4]).
REQ-017 The decode table SHALL map:
- 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000
- 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000
- 8 -> 0000000, 9 -> 0010000, A -> 0001000, B -> 0000011
- C -> 1000110, D -> 0100001, E -> 0000110, F -> 0001110
REQ-018 While blank is high, an SHALL be 2'b11 from the next edge; the prescaler, FSM, snapshot and frame_done SHALL continue unaffected.
REQ-019 When blank falls, an SHALL show the current state's digit from the next edge.
REQ-020 The prescaler and FSM SHALL wrap freely with no terminal state; operation is continuous.

Reset
REQ-021 Asserting reset SHALL immediately (asynchronously) set:
- prescaler to 0
- FSM to DIG0
- snapshot to 8'h00
- an to 2'b10
- seg to 1000000
- frame_done to 0
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; after release, the first tick occurs PRESCALE cycles later.
REQ-023 Until the first frame boundary after reset release, the display SHALL show 00.

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined, in DIG1 with snap[7:4]==0, an SHALL be 2'b11 for that slot; the slot timing SHALL be unchanged.
REQ-025 Without LEADING_ZERO_BLANK_EN, a zero high nibble SHALL be displayed as 0 (seg 1000000, an 2'b01).
REQ-026 The macro SHALL NOT change reset values, timing, or frame_done behaviour.

Verification (PRESCALE=4)
REQ-027 Reset held, then released with count=8'h00 -> an=10 and seg=1000000 at release; an=01 on the 4th edge after release; frame_done=1 after the 8th edge.
REQ-028 count=8'h3A held -> after the first frame_done, seg=0001000 with an=10; 4 cycles later, seg=0110000 with an=01; the pattern repeats.
REQ-029 count changed from 8'h12 to 8'hF0 during DIG1 -> that slot still shows 1; the next frame shows 0 with an=10, then F with an=01.
REQ-030 blank=1 for 10 cycles -> an=11 throughout; frame_done still pulses every 8 cycles; release restores an=10 or 01 per state on the next edge.
REQ-031 count=8'h07 with LEADING_ZERO_BLANK_EN -> the DIG1 slot gives an=11; without the macro, the DIG1 slot gives an=01 and seg=1000000.
REQ-032 Reset asserted in the middle of a DIG1 slot -> outputs go to reset values without waiting for clk; the next frame_done occurs 8 cycles after release.
